// File: rtl/mul_nxn_seq.sv
// mul_nxn_seq -- sequential N x N multiplier, radix-4 (one 2-bit multiplier
// digit per clock), signed or unsigned per operation.
//
// The operands are converted to sign + magnitude when they are accepted.
// The magnitudes are multiplied digit by digit into a 2N-bit accumulator.
// The sign is applied on the last digit edge, when c is registered.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a/b/sgn valid            in_ready   accepting (IDLE only)
//   a, b       N-bit operands           sgn        1 = two's complement
//   out_valid  c holds a product        out_ready  consumer takes c
//   c          2N-bit registered product
//   busy       operation in flight (BUSY or DONE)
module mul_nxn_seq #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic           sgn,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] c,
   output logic           busy
);

   localparam int W  = 2 * N;
   localparam int D  = N / 2;                    // number of radix-4 digits
   localparam int CW = (D > 1) ? $clog2(D) : 1;
   localparam logic [CW-1:0] LAST = CW'(D - 1);

   generate
      if (N < 4 || (N % 2) != 0) begin : g_bad_n
         $error("mul_nxn_seq: N must be even and >= 4");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    mag_a_q, mag_a_d;
   logic [N-1:0]    mag_b_q, mag_b_d;
   logic            neg_q, neg_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    c_q, c_d;
   logic            out_valid_q, out_valid_d;

   logic [N-1:0]    mag_a_in, mag_b_in;
   logic [1:0]      digit;
   logic [N+1:0]    pp;
   logic [W-1:0]    pp_sh;
   logic [W-1:0]    acc_sum;

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments, so every flop
   // samples its pre-edge value regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   // NOTE: every combinational output gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (in_valid)          state_d = S_BUSY;
         S_BUSY: if (cnt_q == LAST)     state_d = S_DONE;
         S_DONE: if (out_ready)         state_d = S_IDLE;
         default:                       state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs (Moore)
   // -------------------------------------------------------------------------
   always_comb begin
      in_ready = (state_q == S_IDLE);
      busy     = (state_q != S_IDLE);
   end

   // -------------------------------------------------------------------------
   // Datapath
   // -------------------------------------------------------------------------
   // The negation of -2^(N-1) wraps back to 2^(N-1). That value is still
   // correct when read as an N-bit unsigned magnitude.
   assign mag_a_in = (sgn && a[N-1]) ? (~a + N'(1)) : a;
   assign mag_b_in = (sgn && b[N-1]) ? (~b + N'(1)) : b;

   // Current multiplier digit times the multiplicand, weighted by 4^k.
   assign digit   = mag_b_q[2*cnt_q +: 2];
   assign pp      = {2'b00, mag_a_q} * {{N{1'b0}}, digit};
   assign pp_sh   = {{(N-2){1'b0}}, pp} << (2 * cnt_q);
   assign acc_sum = acc_q + pp_sh;

   always_comb begin
      mag_a_d     = mag_a_q;
      mag_b_d     = mag_b_q;
      neg_d       = neg_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      c_d         = c_q;
      out_valid_d = out_valid_q;

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mag_a_d = mag_a_in;
               mag_b_d = mag_b_in;
               neg_d   = sgn & (a[N-1] ^ b[N-1]);
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         S_BUSY: begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               c_d         = neg_q ? (~acc_sum + W'(1)) : acc_sum;
               out_valid_d = 1'b1;
            end
         end
         S_DONE: begin
            // c is left untouched so it keeps the last product after the
            // handshake.
            if (out_ready) out_valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   // NOTE: every register, including the operand latches, is cleared on
   // reset. An aborted operation therefore leaves no residue behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_a_q     <= '0;
         mag_b_q     <= '0;
         neg_q       <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         c_q         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         mag_a_q     <= mag_a_d;
         mag_b_q     <= mag_b_d;
         neg_q       <= neg_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         c_q         <= c_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign c         = c_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mul_nxn_seq.sv
// Testbench for mul_nxn_seq.
// The N=8 instance runs a table of directed products, a stall sequence and a
// reset abort. The N=4 instance is swept over every operand pair in both sign
// modes. The N=16 instance runs random operands against a golden model, with
// random consumer stalls.
module tb_mul_nxn_seq;

   logic clk;
   logic rst_n;
   int   cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Golden product of n-bit operands, taken modulo 2^(2n).
   function automatic logic [31:0] golden(input int n, input logic s,
                                          input logic [15:0] av, input logic [15:0] bv);
      longint sa, sb, p;
      sa = longint'(av);
      sb = longint'(bv);
      if (s && av[n-1]) sa = sa - (longint'(1) << n);
      if (s && bv[n-1]) sb = sb - (longint'(1) << n);
      p = sa * sb;
      return 32'(p & ((longint'(1) << (2 * n)) - 1));
   endfunction

   // ---------------- N = 8 instance ----------------
   logic        in_valid8, in_ready8, sgn8, out_valid8, out_ready8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] c8;

   mul_nxn_seq #(.N(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .sgn(sgn8), .out_valid(out_valid8), .out_ready(out_ready8),
      .c(c8), .busy(busy8));

   // ---------------- N = 4 instance ----------------
   logic        in_valid4, in_ready4, sgn4, out_valid4, out_ready4, busy4;
   logic [3:0]  a4, b4;
   logic [7:0]  c4;

   mul_nxn_seq #(.N(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .sgn(sgn4), .out_valid(out_valid4), .out_ready(out_ready4),
      .c(c4), .busy(busy4));

   // ---------------- N = 16 instance ----------------
   logic        in_valid16, in_ready16, sgn16, out_valid16, out_ready16, busy16;
   logic [15:0] a16, b16;
   logic [31:0] c16;

   mul_nxn_seq #(.N(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .sgn(sgn16), .out_valid(out_valid16), .out_ready(out_ready16),
      .c(c16), .busy(busy16));

   typedef struct {
      logic        sgn;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] c;
   } vec8_t;

   vec8_t vt[12];

   // One N=8 operation.
   // The task accepts the operands, then disturbs the inputs while the
   // operation is in flight. It counts the edges until out_valid rises.
   task automatic run8(input logic s, input logic [7:0] av, input logic [7:0] bv,
                       output logic [15:0] cv, output int lat);
      @(negedge clk);
      check("n8 in_ready before accept", 64'(in_ready8), 64'd1);
      sgn8 = s; a8 = av; b8 = bv; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0; a8 = ~av; b8 = 8'h5A; sgn8 = ~s;
      check("n8 in_ready low in BUSY", 64'(in_ready8), 64'd0);
      check("n8 busy high in BUSY", 64'(busy8), 64'd1);
      lat = 0;
      while (!out_valid8 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      cv = c8;
   endtask

   initial begin
      logic [15:0] cv;
      int          lat;
      bit          seen;
      logic [31:0] q4[$];
      logic [31:0] q16[$];
      logic [31:0] ex;
      int          idx, got, budget, last_cyc, sent;

      vt[0]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
      vt[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
      vt[2]  = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
      vt[3]  = '{1'b1, 8'h00, 8'h80, 16'h0000};
      vt[4]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
      vt[5]  = '{1'b1, 8'h7F, 8'h80, 16'hC080};
      vt[6]  = '{1'b0, 8'h12, 8'h34, 16'h03A8};
      vt[7]  = '{1'b1, 8'hFE, 8'hFD, 16'h0006};
      vt[8]  = '{1'b0, 8'h00, 8'hFF, 16'h0000};
      vt[9]  = '{1'b1, 8'h05, 8'hFB, 16'hFFE7};
      vt[10] = '{1'b1, 8'h80, 8'h01, 16'hFF80};
      vt[11] = '{1'b0, 8'h01, 8'h80, 16'h0080};

      cyc = 0;
      rst_n = 1'b0;
      in_valid8 = 0; sgn8 = 0; a8 = 0; b8 = 0; out_ready8 = 1;
      in_valid4 = 0; sgn4 = 0; a4 = 0; b4 = 0; out_ready4 = 1;
      in_valid16 = 0; sgn16 = 0; a16 = 0; b16 = 0; out_ready16 = 1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready", 64'(in_ready8), 64'd1);
      check("reset busy", 64'(busy8), 64'd0);
      check("reset out_valid", 64'(out_valid8), 64'd0);
      check("reset c", 64'(c8), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table, N=8
      for (int i = 0; i < 12; i++) begin
         run8(vt[i].sgn, vt[i].a, vt[i].b, cv, lat);
         check($sformatf("n8 vec%0d latency", i), 64'(lat), 64'd4);
         check($sformatf("n8 vec%0d product", i), 64'(cv), 64'(vt[i].c));
         @(posedge clk); #1;
         check($sformatf("n8 vec%0d handshake", i), 64'(out_valid8), 64'd0);
      end

      // Consumer stall while new operands are offered
      out_ready8 = 1'b0;
      run8(1'b1, 8'hFF, 8'hFF, cv, lat);
      check("stall latency", 64'(lat), 64'd4);
      check("stall product", 64'(cv), 64'h0001);
      in_valid8 = 1'b1; a8 = 8'h03; b8 = 8'h05; sgn8 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall c stable", 64'(c8), 64'h0001);
         check("stall out_valid held", 64'(out_valid8), 64'd1);
         check("stall in_ready low", 64'(in_ready8), 64'd0);
      end
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      check("stall release out_valid", 64'(out_valid8), 64'd0);
      check("stall release in_ready", 64'(in_ready8), 64'd1);
      check("c retained after handshake", 64'(c8), 64'h0001);
      @(posedge clk); #1;
      check("pending in_valid accepted", 64'(in_ready8), 64'd0);
      in_valid8 = 1'b0; a8 = 8'hAA; b8 = 8'hAA;
      lat = 0;
      while (!out_valid8 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("pending latency", 64'(lat), 64'd4);
      check("pending product", 64'(c8), 64'h000F);
      @(posedge clk); #1;

      // Reset during the second BUSY cycle
      @(negedge clk);
      sgn8 = 1'b0; a8 = 8'h7F; b8 = 8'h7F; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort out_valid", 64'(out_valid8), 64'd0);
      check("abort c cleared", 64'(c8), 64'd0);
      check("abort in_ready", 64'(in_ready8), 64'd1);
      check("abort busy", 64'(busy8), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid8) seen = 1'b1;
      end
      check("no stale result after abort", 64'(seen), 64'd0);
      run8(1'b0, 8'h7F, 8'h7F, cv, lat);
      check("post-reset latency", 64'(lat), 64'd4);
      check("post-reset product", 64'(cv), 64'h3F01);
      @(posedge clk); #1;

      // N=4 exhaustive, back-to-back, in_valid and out_ready held high
      idx = 0; got = 0; budget = 0; last_cyc = -1;
      out_ready4 = 1'b1;
      in_valid4 = 1'b1;
      while (got < 512 && budget < 3000) begin
         @(negedge clk);
         budget++;
         if (out_valid4) begin
            if (q4.size() > 0) begin
               ex = q4.pop_front();
               check("n4 product", 64'(c4), 64'(ex));
            end else begin
               check("n4 unexpected result", 64'(out_valid4), 64'd0);
            end
            if (last_cyc >= 0) check("n4 result interval", 64'(cyc - last_cyc), 64'd4);
            last_cyc = cyc;
            got++;
         end
         if (in_ready4) begin
            if (idx < 512) begin
               sgn4 = idx[8]; a4 = idx[7:4]; b4 = idx[3:0];
               q4.push_back(golden(4, idx[8], {12'd0, idx[7:4]}, {12'd0, idx[3:0]}));
               idx++;
            end else begin
               in_valid4 = 1'b0;
            end
         end
      end
      in_valid4 = 1'b0;
      if (got < 512) check("n4 timeout", 64'(got), 64'd512);

      // N=16 random operands with random consumer stalls
      sent = 0; got = 0; budget = 0;
      while (got < 40 && budget < 4000) begin
         @(negedge clk);
         budget++;
         out_ready16 = ($urandom_range(0, 2) != 0);
         if (out_valid16 && out_ready16) begin
            if (q16.size() > 0) begin
               ex = q16.pop_front();
               check($sformatf("n16 product %0d", got), 64'(c16), 64'(ex));
            end else begin
               check("n16 unexpected result", 64'(out_valid16), 64'd0);
            end
            got++;
         end
         in_valid16 = 1'b0;
         if (in_ready16 && sent < 40 && $urandom_range(0, 3) != 0) begin
            if (sent == 0) begin
               sgn16 = 1'b1; a16 = 16'h8000; b16 = 16'h8000;
            end else if (sent == 1) begin
               sgn16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hFFFF;
            end else begin
               sgn16 = 1'($urandom_range(0, 1));
               a16 = 16'($urandom);
               b16 = 16'($urandom);
            end
            in_valid16 = 1'b1;
            q16.push_back(golden(16, sgn16, a16, b16));
            sent++;
         end
      end
      in_valid16 = 1'b0;
      if (got < 40) check("n16 timeout", 64'(got), 64'd40);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
